// File: rtl/ser_tx_clk_rstb_if.sv
// Word handshake between a producer and the serial frame transmitter.
interface ser_tx_clk_rstb_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ser_tx_clk_rstb.sv
// Parallel-to-serial frame transmitter: start(0), data LSB-first,
// optional even parity, stop(1); each bit lasts CLKS_PER_BIT clocks.
module ser_tx_clk_rstb #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1
) (
   input  logic                     clk,
   input  logic                     rstb,
   ser_tx_clk_rstb_if.slave         bus,
   output logic                     out_ser,
   output logic                     out_busy,
   output logic                     out_done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [IDX_W-1:0]    idx, idx_nxt;
   logic [DATA_W-1:0]   shift_reg, shift_nxt;
   logic [DATA_W-1:0]   shifted;
   logic                par, par_nxt;
   logic                ser_nxt, busy_nxt, ready_nxt, done_nxt;
   logic                ready;
   logic                bit_end;

   assign bit_end      = (cnt == CNT_LAST);
   assign shifted      = shift_reg >> 1;
   assign bus.in_ready = ready;

   // Next-state and next-output logic; outputs are registered below.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_nxt = state;
      cnt_nxt   = bit_end ? '0 : cnt + 1'b1;
      idx_nxt   = idx;
      shift_nxt = shift_reg;
      par_nxt   = par;
      ser_nxt   = 1'b1;
      busy_nxt  = 1'b1;
      ready_nxt = 1'b0;
      done_nxt  = 1'b0;

      unique case (state)
         IDLE: begin
            cnt_nxt   = '0;
            busy_nxt  = 1'b0;
            ready_nxt = 1'b1;
            // in_ready is high exactly in IDLE, so in_valid alone marks acceptance here
            if (bus.in_valid) begin
               shift_nxt = bus.in_data;
               par_nxt   = ^bus.in_data;
               state_nxt = START;
               ser_nxt   = 1'b0;
               busy_nxt  = 1'b1;
               ready_nxt = 1'b0;
            end
         end
         START: begin
            ser_nxt = 1'b0;
            if (bit_end) begin
               state_nxt = DATA;
               idx_nxt   = '0;
               ser_nxt   = shift_reg[0];
            end
         end
         DATA: begin
            ser_nxt = shift_reg[0];
            if (bit_end) begin
               if (idx == IDX_LAST) begin
                  if (PARITY_EN != 0) begin
                     state_nxt = PARITY;
                     ser_nxt   = par;
                  end else begin
                     state_nxt = STOP;
                     ser_nxt   = 1'b1;
                  end
               end else begin
                  idx_nxt   = idx + 1'b1;
                  shift_nxt = shifted;
                  ser_nxt   = shifted[0];
               end
            end
         end
         PARITY: begin
            ser_nxt = par;
            if (bit_end) begin
               state_nxt = STOP;
               ser_nxt   = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               ready_nxt = 1'b1;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            busy_nxt  = 1'b0;
            ready_nxt = 1'b1;
         end
      endcase
   end

   // State, datapath and registered outputs with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rstb) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shift_reg <= '0;
         par       <= 1'b0;
         out_ser   <= 1'b1;
         out_busy  <= 1'b0;
         out_done  <= 1'b0;
         ready     <= 1'b1;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         idx       <= idx_nxt;
         shift_reg <= shift_nxt;
         par       <= par_nxt;
         out_ser   <= ser_nxt;
         out_busy  <= busy_nxt;
         out_done  <= done_nxt;
         ready     <= ready_nxt;
      end
   end

endmodule

// File: tb/tb_ser_tx_clk_rstb.sv
// Directed bench for ser_tx_clk_rstb: default config (8/4/parity) on dut_a,
// CLKS_PER_BIT=1 without parity on dut_b. Expected frames are hand-written
// bit strings in line order: start, data LSB-first, [parity], stop.
module tb_ser_tx_clk_rstb;

   logic clk  = 1'b0;
   logic rstb = 1'b0;
   logic ser_a, busy_a, done_a;
   logic ser_b, busy_b, done_b;
   int   n_tests = 0;
   int   n_fail  = 0;

   ser_tx_clk_rstb_if #(.DATA_W(8)) if_a ();
   ser_tx_clk_rstb_if #(.DATA_W(8)) if_b ();

   ser_tx_clk_rstb #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (
      .clk(clk), .rstb(rstb), .bus(if_a),
      .out_ser(ser_a), .out_busy(busy_a), .out_done(done_a)
   );

   ser_tx_clk_rstb #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (
      .clk(clk), .rstb(rstb), .bus(if_b),
      .out_ser(ser_b), .out_busy(busy_b), .out_done(done_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sel_ser(input bit sel);
      return sel ? ser_b : ser_a;
   endfunction
   function automatic logic sel_busy(input bit sel);
      return sel ? busy_b : busy_a;
   endfunction
   function automatic logic sel_done(input bit sel);
      return sel ? done_b : done_a;
   endfunction
   function automatic logic sel_ready(input bit sel);
      return sel ? if_b.in_ready : if_a.in_ready;
   endfunction

   // Called in cycle 1 after the accept edge; ends in the out_done cycle.
   task automatic frame_check(input string tag, input string bits, input int cpb,
                              input bit sel, input bit toggle);
      int n;
      n = bits.len() * cpb;
      for (int c = 1; c <= n; c++) begin
         check({tag, " ser"},   32'(sel_ser(sel)),   32'(bits[(c-1)/cpb] == "1"));
         check({tag, " busy"},  32'(sel_busy(sel)),  32'd1);
         check({tag, " ready"}, 32'(sel_ready(sel)), 32'd0);
         check({tag, " done"},  32'(sel_done(sel)),  32'd0);
         if (toggle) begin
            if_a.in_valid = (c == n) ? 1'b0 : ~if_a.in_valid;
            if_a.in_data  = 8'($urandom);
         end
         tick();
      end
      check({tag, " done pulse"}, 32'(sel_done(sel)),  32'd1);
      check({tag, " end ready"},  32'(sel_ready(sel)), 32'd1);
      check({tag, " end busy"},   32'(sel_busy(sel)),  32'd0);
      check({tag, " end ser"},    32'(sel_ser(sel)),   32'd1);
   endtask

   // Present a word to dut_a and take the accepting edge.
   task automatic accept_a(input logic [7:0] d);
      if_a.in_valid = 1'b1;
      if_a.in_data  = d;
      tick();
      if_a.in_valid = 1'b0;
   endtask

   initial begin
      if_a.in_valid = 1'b1;
      if_a.in_data  = 8'hFF;
      if_b.in_valid = 1'b1;
      if_b.in_data  = 8'hFF;

      // Reset held for three edges with in_valid asserted
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst ser",   32'(ser_a),         32'd1);
         check("rst ready", 32'(if_a.in_ready), 32'd1);
         check("rst busy",  32'(busy_a),        32'd0);
         check("rst done",  32'(done_a),        32'd0);
         check("rst ser_b", 32'(ser_b),         32'd1);
      end
      if_a.in_valid = 1'b0;
      if_b.in_valid = 1'b0;
      rstb = 1'b1;
      tick();
      tick();
      check("idle after rst ser",  32'(ser_a),  32'd1);
      check("idle after rst busy", 32'(busy_a), 32'd0);

      // Single frame 0xA5: four ones -> parity 0
      accept_a(8'hA5);
      frame_check("a5", "01010010101", 4, 1'b0, 1'b0);
      tick();
      check("a5 done clears", 32'(done_a), 32'd0);

      // Odd ones count -> parity 1; all-zero word -> parity 0
      accept_a(8'h07);
      frame_check("07", "01110000011", 4, 1'b0, 1'b0);
      tick();
      accept_a(8'h00);
      frame_check("00", "00000000001", 4, 1'b0, 1'b0);
      tick();

      // Back-to-back with in_valid held: 2nd word loaded while busy must be the one sent next
      if_a.in_valid = 1'b1;
      if_a.in_data  = 8'h3C;
      tick();
      if_a.in_data  = 8'hC3;
      frame_check("3c", "00011110001", 4, 1'b0, 1'b0);
      tick();
      if_a.in_valid = 1'b0;
      frame_check("c3", "01100001101", 4, 1'b0, 1'b0);
      tick();
      check("c3 done clears", 32'(done_a), 32'd0);

      // Busy-ignore: inputs toggle throughout the frame
      accept_a(8'hA5);
      frame_check("ign", "01010010101", 4, 1'b0, 1'b1);
      tick();

      // Mid-frame reset during data bit 3
      accept_a(8'h07);
      for (int i = 0; i < 16; i++) tick();
      check("pre-rst busy", 32'(busy_a), 32'd1);
      check("pre-rst ser",  32'(ser_a),  32'd0);
      rstb = 1'b0;
      if_a.in_valid = 1'b1;
      tick();
      check("mid rst ser",   32'(ser_a),         32'd1);
      check("mid rst busy",  32'(busy_a),        32'd0);
      check("mid rst ready", 32'(if_a.in_ready), 32'd1);
      check("mid rst done",  32'(done_a),        32'd0);
      rstb = 1'b1;
      if_a.in_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         check("post rst no done", 32'(done_a), 32'd0);
         check("post rst ser",     32'(ser_a),  32'd1);
      end
      accept_a(8'h00);
      frame_check("fresh", "00000000001", 4, 1'b0, 1'b0);
      tick();

      // Corner config: one clock per bit, no parity
      if_b.in_valid = 1'b1;
      if_b.in_data  = 8'h80;
      tick();
      if_b.in_valid = 1'b0;
      frame_check("c1", "0000000011", 1, 1'b1, 1'b0);
      tick();
      check("c1 done clears", 32'(done_b), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
